ucie_ctl_sb_rx_deser: RTL and testbench
=======================================

# ucie_ctl_sb_rx_deser

Sideband receive deserializer sitting directly upstream of the sideband RX FSM. It gathers NC-bit beats from the physical-layer sideband receive path into 32-bit phase words and pulses `o_count_done` as each word completes. It presents the per-packet valid and forwards the FSM's credit back to the sender. It also detects aborted frames and beats that arrive without credit.

## Interface
- `NC`, 8: beat width in bits. Legal values: 1, 2, 4, 8, 16, 32.
- `i_clk` input 1: clock.
- `i_rst` input 1: asynchronous, active-low reset.
- `i_pl_cfg` input NC: sideband beat, LSB-first within a phase.
- `i_pl_cfg_vld` input 1: beat valid. The sender holds it high for the whole packet.
- `i_fsm_crd` input 1: credit from the RX FSM; high when the FSM is idle.
- `o_cfg_crd` output 1: credit to the sender.
- `o_pl_cfg_vld` output 1: packet valid to the RX FSM.
- `o_count_done` output 1: one-cycle pulse when a 32-bit phase word is complete.
- `o_received_data` output 32: last completed phase word.
- `o_phase_idx` output 2: index (0–3) of the phase currently being collected.
- `o_frame_error` output 1: one-cycle pulse on an aborted packet.
- `o_overflow` output 1: one-cycle pulse when a packet starts without credit.

## Operation
- Beats per phase: BPP = 32/NC. Beat counter width is max(1, clog2(BPP)).
- Beat k of a phase lands in `o_received_data[k*NC +: NC]`.
- Each packet is 4 phases (header 0, header 1, data 0, data 1).
- FSM states:
  - S_IDLE:
    - `i_pl_cfg_vld`=1 and `i_fsm_crd`=1: accept the beat as beat 0 of phase 0, go to S_BEAT.
    - `i_pl_cfg_vld`=1 and `i_fsm_crd`=0: pulse `o_overflow`, go to S_DROP.
  - S_BEAT: every cycle with `i_pl_cfg_vld`=1 accepts one beat.
    - On the last beat of a phase, the word is registered into `o_received_data` and `o_count_done` pulses.
    - The phase index then increments.
    - After phase 3 completes, go to S_IDLE.
    - `i_pl_cfg_vld`=0 in S_BEAT (mid-phase or between phases): discard the partial word, clear the beat and phase counters, go to S_IDLE, and pulse `o_frame_error`.
  - S_DROP: discard beats; return to S_IDLE on the first cycle with `i_pl_cfg_vld`=0.
- `o_received_data` holds its value until the next completed word. It is not cleared on abort.
- `o_cfg_crd` = `i_fsm_crd` & (state==S_IDLE). This path is combinational.
- Reset values: all outputs 0, except `o_cfg_crd`, which follows `i_fsm_crd`. State is S_IDLE and all counters are 0.
- Reset asserted mid-packet: all state clears immediately. No `o_count_done` or error pulse is produced for the partial packet.
- If NC does not divide 32, elaboration fails (`$error`).

## Timing
- First beat accepted at cycle t: `o_pl_cfg_vld`=1 from t+1.
- Last beat of phase p arrives at t+(p+1)·BPP−1: `o_count_done` is high, with data valid, at t+(p+1)·BPP.
- `o_pl_cfg_vld` drops the cycle after the phase-3 `o_count_done`. It also drops one cycle after `i_pl_cfg_vld` falls on an abort.
- `o_frame_error` and `o_overflow` are registered and appear one cycle after the causing beat or edge.
- Back-to-back packets: S_IDLE accepts a new first beat only when `i_fsm_crd`=1. A beat sent earlier counts as overflow.

## Configuration
- `UCIE_CTL_SB_RX_DESER_FRAME_CHK_EN` (in defines.svh).
- Defined: abort and overflow detection as above.
- Undefined:
  - `o_frame_error` and `o_overflow` are tied to 0.
  - An abort still flushes silently.
  - A no-credit start is accepted as a normal packet (no S_DROP).

## Structure
- Shared package `ucie_ctl_sb_pkg` holds:
  - state encoding (S_IDLE, S_BEAT, S_DROP);
  - SB_PHASE_W=32;
  - SB_PHASES_PER_PKT=4.
- Sub-module `ucie_ctl_sb_beat_shifter` holds the beat counter and the word assembly. Its ports are beat in, accept, flush, word out and last-beat flag.
- The top level holds the FSM, phase counter, credit and error logic.

## Test plan
- Reset: hold `i_rst`=0 and toggle `i_fsm_crd` -> all outputs 0 and `o_cfg_crd` mirrors `i_fsm_crd`.
- NC=8, full packet:
  - Stimulus: crd=1; beats 1B,00,05,20 | 01,00,00,05 | 78,56,34,12 | 01,00,00,00 starting at cycle 1.
  - Required: `o_count_done` at cycles 5, 9, 13, 17.
  - Required words: 0x2005001B, 0x05000001, 0x12345678, 0x00000001.
  - Required: `o_pl_cfg_vld` high over cycles 2–17.
- Abort: `i_pl_cfg_vld` falls after 6 beats -> one `o_count_done` only, `o_frame_error` pulse, `o_phase_idx`=0, `o_pl_cfg_vld` low the next cycle.
- No credit: crd=0 with 8 beats -> `o_overflow` pulse, no `o_count_done`, S_IDLE after vld falls. With the macro undefined, the same stimulus yields 2 `o_count_done` pulses instead.
- NC=1: 32 beats of pattern A5A5A5A5, LSB first -> `o_count_done` at beat 32+1 with 0xA5A5A5A5.
- Reset asserted during phase 2 beat 2 -> immediate clear, no pulse; after release, a fresh packet decodes correctly.

Source files
------------

// File: rtl/ucie_ctl_sb_pkg.sv
// ucie_ctl_sb_pkg
// Shared definitions for the sideband control blocks: the RX deserializer
// state encoding, the phase word width, the number of phases per packet and
// a helper that sizes the beat counter for a given beat width.
package ucie_ctl_sb_pkg;

    localparam int SB_PHASE_W        = 32;
    localparam int SB_PHASES_PER_PKT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEAT = 2'd1,
        S_DROP = 2'd2
    } sb_rx_state_e;

    // Beat counter width: max(1, clog2(beats per phase)).
    function automatic int sb_beat_cnt_w(input int nc);
        int bpp;
        bpp = (nc > 0) ? (SB_PHASE_W / nc) : 1;
        return (bpp > 1) ? $clog2(bpp) : 1;
    endfunction

endpackage

// File: rtl/ucie_ctl_sb_beat_shifter.sv
// ucie_ctl_sb_beat_shifter
// Assembles NC-bit beats into a 32-bit phase word, LSB-first.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-low reset
//   beat_in       current beat
//   accept        beat_in is taken this cycle
//   flush         discard the partial word and restart at beat 0
//   word_out      partial word with the current beat already merged in, so
//                 the parent can register the complete word on the last beat
//   last_beat     the current beat is the final beat of the phase
module ucie_ctl_sb_beat_shifter
    import ucie_ctl_sb_pkg::*;
#(
    parameter int NC = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NC-1:0]         beat_in,
    input  logic                  accept,
    input  logic                  flush,
    output logic [SB_PHASE_W-1:0] word_out,
    output logic                  last_beat
);

    localparam int BPP = SB_PHASE_W / NC;
    localparam int CW  = sb_beat_cnt_w(NC);

    logic [CW-1:0]         cnt_q;
    logic [SB_PHASE_W-1:0] shift_q;

    assign last_beat = (cnt_q == CW'(BPP - 1));

    // Overlay the incoming beat on the bits collected so far.
    always_comb begin
        word_out = shift_q;
        word_out[int'(cnt_q) * NC +: NC] = beat_in;
    end

    // The partial word is cleared once it completes so a fresh phase starts
    // from zero; the completed copy lives in the parent.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (flush) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (accept) begin
            if (last_beat) begin
                cnt_q   <= '0;
                shift_q <= '0;
            end else begin
                cnt_q   <= cnt_q + 1'b1;
                shift_q <= word_out;
            end
        end
    end

endmodule

// File: rtl/ucie_ctl_sb_rx_deser.sv
// ucie_ctl_sb_rx_deser
// Sideband receive deserializer: gathers NC-bit beats into 32-bit phase
// words (4 phases per packet), pulses o_count_done per completed word,
// presents packet valid and forwards the RX FSM credit to the sender.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-low reset
//   i_pl_cfg          sideband beat (NC bits, LSB-first within a phase)
//   i_pl_cfg_vld      beat valid, held high for a whole packet
//   i_fsm_crd         credit from the RX FSM (high when it is idle)
//   o_cfg_crd         credit to the sender (combinational)
//   o_pl_cfg_vld      packet valid to the RX FSM
//   o_count_done      one-cycle pulse per completed phase word
//   o_received_data   last completed phase word
//   o_phase_idx       phase currently being collected
//   o_frame_error     one-cycle pulse on an aborted packet
//   o_overflow        one-cycle pulse when a packet starts without credit
// Optional frame checking: define UCIE_CTL_SB_RX_DESER_FRAME_CHK_EN to enable
// abort/overflow reporting and dropping of no-credit packets. Without it the
// error outputs are tied low, aborts flush silently and no-credit starts are
// accepted as normal packets.
module ucie_ctl_sb_rx_deser
    import ucie_ctl_sb_pkg::*;
#(
    parameter int NC = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NC-1:0]         i_pl_cfg,
    input  logic                  i_pl_cfg_vld,
    input  logic                  i_fsm_crd,
    output logic                  o_cfg_crd,
    output logic                  o_pl_cfg_vld,
    output logic                  o_count_done,
    output logic [SB_PHASE_W-1:0] o_received_data,
    output logic [1:0]            o_phase_idx,
    output logic                  o_frame_error,
    output logic                  o_overflow
);

    if ((SB_PHASE_W % NC) != 0) begin : g_nc_check
        $error("ucie_ctl_sb_rx_deser: NC=%0d does not divide %0d", NC, SB_PHASE_W);
    end

    sb_rx_state_e          state_q;
    sb_rx_state_e          state_d;
    logic [1:0]            phase_q;
    logic                  accept;
    logic                  flush;
    logic                  last_beat;
    logic                  word_done;
    logic [SB_PHASE_W-1:0] word;
`ifdef UCIE_CTL_SB_RX_DESER_FRAME_CHK_EN
    logic                  overflow_d;
    logic                  frame_error_q;
    logic                  overflow_q;
`endif

    ucie_ctl_sb_beat_shifter #(
        .NC (NC)
    ) u_shifter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .beat_in   (i_pl_cfg),
        .accept    (accept),
        .flush     (flush),
        .word_out  (word),
        .last_beat (last_beat)
    );

    assign word_done   = accept & last_beat;
    assign o_cfg_crd   = i_fsm_crd & (state_q == S_IDLE);
    assign o_phase_idx = phase_q;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and beat control. A valid drop while collecting is an
    // abort, whether mid-phase or between phases.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        flush   = 1'b0;
`ifdef UCIE_CTL_SB_RX_DESER_FRAME_CHK_EN
        overflow_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_pl_cfg_vld) begin
`ifdef UCIE_CTL_SB_RX_DESER_FRAME_CHK_EN
                    if (i_fsm_crd) begin
                        accept  = 1'b1;
                        state_d = S_BEAT;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = S_DROP;
                    end
`else
                    accept  = 1'b1;
                    state_d = S_BEAT;
`endif
                end
            end
            S_BEAT: begin
                if (i_pl_cfg_vld) begin
                    accept = 1'b1;
                    if (last_beat && (phase_q == 2'(SB_PHASES_PER_PKT - 1))) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (!i_pl_cfg_vld) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Packet valid follows accepted beats by one cycle; the completed word
    // is held until the next one completes and survives aborts.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_pl_cfg_vld    <= 1'b0;
            o_count_done    <= 1'b0;
            o_received_data <= '0;
            phase_q         <= 2'd0;
        end else begin
            o_pl_cfg_vld <= accept;
            o_count_done <= word_done;
            if (word_done) begin
                o_received_data <= word;
            end
            if (flush) begin
                phase_q <= 2'd0;
            end else if (word_done) begin
                phase_q <= phase_q + 2'd1;
            end
        end
    end

`ifdef UCIE_CTL_SB_RX_DESER_FRAME_CHK_EN
    // Error pulses, registered one cycle after the causing beat or edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            frame_error_q <= flush;
            overflow_q    <= overflow_d;
        end
    end

    assign o_frame_error = frame_error_q;
    assign o_overflow    = overflow_q;
`else
    assign o_frame_error = 1'b0;
    assign o_overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_ucie_ctl_sb_rx_deser.sv
// tb_ucie_ctl_sb_rx_deser
// Bench for ucie_ctl_sb_rx_deser with two instances (NC=8 and NC=1) sharing
// clock, reset, valid and credit. A packet-level reference model predicts
// every output each cycle; directed scenarios pin the model with literal
// words, pulse cycles and pulse counts.
module tb_ucie_ctl_sb_rx_deser;

`ifdef UCIE_CTL_SB_RX_DESER_FRAME_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam int NC_A = 8;
    localparam int NC_B = 1;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        vld   = 1'b0;
    logic        crd   = 1'b0;
    logic [7:0]  beat_a = '0;
    logic [0:0]  beat_b = '0;

    logic        a_cfg_crd, a_pl_cfg_vld, a_count_done, a_frame_error, a_overflow;
    logic [31:0] a_received_data;
    logic [1:0]  a_phase_idx;
    logic        b_cfg_crd, b_pl_cfg_vld, b_count_done, b_frame_error, b_overflow;
    logic [31:0] b_received_data;
    logic [1:0]  b_phase_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int a_done_cyc[$];
    logic [31:0] a_done_dat[$];
    int b_done_cyc[$];
    logic [31:0] b_done_dat[$];
    int a_ferr_n  = 0;
    int a_ovf_n   = 0;
    int a_plvld_n = 0;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    ucie_ctl_sb_rx_deser #(.NC(NC_A)) dut_a (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_pl_cfg        (beat_a),
        .i_pl_cfg_vld    (vld),
        .i_fsm_crd       (crd),
        .o_cfg_crd       (a_cfg_crd),
        .o_pl_cfg_vld    (a_pl_cfg_vld),
        .o_count_done    (a_count_done),
        .o_received_data (a_received_data),
        .o_phase_idx     (a_phase_idx),
        .o_frame_error   (a_frame_error),
        .o_overflow      (a_overflow)
    );

    ucie_ctl_sb_rx_deser #(.NC(NC_B)) dut_b (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_pl_cfg        (beat_b),
        .i_pl_cfg_vld    (vld),
        .i_fsm_crd       (crd),
        .o_cfg_crd       (b_cfg_crd),
        .o_pl_cfg_vld    (b_pl_cfg_vld),
        .o_count_done    (b_count_done),
        .o_received_data (b_received_data),
        .o_phase_idx     (b_phase_idx),
        .o_frame_error   (b_frame_error),
        .o_overflow      (b_overflow)
    );

    // Packet-level view: in a packet or dropping one, beats taken so far,
    // and the outputs that follow from the beat taken (or not) this cycle.
    typedef struct {
        bit          busy;
        bit          dropping;
        int          nbeats;
        logic [31:0] acc;
        logic [31:0] data;
        int          phase;
        bit          plvld;
        bit          done;
        bit          ferr;
        bit          ovf;
    } model_t;

    model_t ma;
    model_t mb;

    function automatic model_t model_reset();
        model_t m;
        m.busy = 0; m.dropping = 0; m.nbeats = 0; m.acc = '0; m.data = '0;
        m.phase = 0; m.plvld = 0; m.done = 0; m.ferr = 0; m.ovf = 0;
        return m;
    endfunction

    function automatic model_t take_beat(model_t m_in, int nc, logic [31:0] b);
        model_t m;
        int bpp;
        m = m_in;
        bpp = 32 / nc;
        m.acc = m.acc | (b << ((m.nbeats % bpp) * nc));
        m.nbeats++;
        m.plvld = 1;
        if ((m.nbeats % bpp) == 0) begin
            m.done  = 1;
            m.data  = m.acc;
            m.acc   = '0;
            m.phase = (m.nbeats / bpp) % 4;
            if (m.nbeats == 4 * bpp) begin
                m.busy   = 0;
                m.nbeats = 0;
            end
        end
        return m;
    endfunction

    function automatic model_t model_step(model_t m_in, int nc, bit v, bit c, logic [31:0] b);
        model_t m;
        m = m_in;
        m.plvld = 0; m.done = 0; m.ferr = 0; m.ovf = 0;
        if (m.dropping) begin
            if (!v) m.dropping = 0;
        end else if (m.busy) begin
            if (v) begin
                m = take_beat(m, nc, b);
            end else begin
                m.busy = 0; m.nbeats = 0; m.acc = '0; m.phase = 0;
                m.ferr = CHK;
            end
        end else if (v) begin
            if (c || !CHK) begin
                m.busy = 1;
                m = take_beat(m, nc, b);
            end else begin
                m.dropping = 1;
                m.ovf = 1;
            end
        end
        return m;
    endfunction

    initial begin
        ma = model_reset();
        mb = model_reset();
    end

    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ma = model_reset();
            mb = model_reset();
        end else begin
            ma = model_step(ma, NC_A, vld, crd, {24'b0, beat_a});
            mb = model_step(mb, NC_B, vld, crd, {31'b0, beat_b});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Every-cycle comparison against the model, plus event logs for the
    // directed literal checks. Pulses are stamped with the cycle they are
    // visible in, counting the cycle a beat is presented as its own.
    always @(negedge i_clk) begin
        checkOutput("a_cfg_crd",  32'(a_cfg_crd),     32'(crd & ~ma.busy & ~ma.dropping));
        checkOutput("a_pl_vld",   32'(a_pl_cfg_vld),  32'(ma.plvld));
        checkOutput("a_done",     32'(a_count_done),  32'(ma.done));
        checkOutput("a_data",     a_received_data,    ma.data);
        checkOutput("a_phase",    32'(a_phase_idx),   32'(ma.phase));
        checkOutput("a_ferr",     32'(a_frame_error), 32'(ma.ferr));
        checkOutput("a_ovf",      32'(a_overflow),    32'(ma.ovf));
        checkOutput("b_cfg_crd",  32'(b_cfg_crd),     32'(crd & ~mb.busy & ~mb.dropping));
        checkOutput("b_pl_vld",   32'(b_pl_cfg_vld),  32'(mb.plvld));
        checkOutput("b_done",     32'(b_count_done),  32'(mb.done));
        checkOutput("b_data",     b_received_data,    mb.data);
        checkOutput("b_phase",    32'(b_phase_idx),   32'(mb.phase));
        checkOutput("b_ferr",     32'(b_frame_error), 32'(mb.ferr));
        checkOutput("b_ovf",      32'(b_overflow),    32'(mb.ovf));
        if (a_count_done) begin
            a_done_cyc.push_back(cyc + 1);
            a_done_dat.push_back(a_received_data);
        end
        if (b_count_done) begin
            b_done_cyc.push_back(cyc + 1);
            b_done_dat.push_back(b_received_data);
        end
        if (a_frame_error) a_ferr_n++;
        if (a_overflow)    a_ovf_n++;
        if (a_pl_cfg_vld)  a_plvld_n++;
    end

    task automatic applyStimulus(input logic v, input logic c, input logic [7:0] ba, input logic bb);
        vld       = v;
        crd       = c;
        beat_a    = ba;
        beat_b[0] = bb;
        @(posedge i_clk);
        #2;
    endtask

    task automatic clearLogs();
        a_done_cyc.delete();
        a_done_dat.delete();
        b_done_cyc.delete();
        b_done_dat.delete();
        a_ferr_n  = 0;
        a_ovf_n   = 0;
        a_plvld_n = 0;
    endtask

    task automatic checkWords(input string tag, input int t0, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] exp_w[4];
        exp_w = '{w0, w1, w2, w3};
        checkOutput({tag, "_done_count"}, 32'(a_done_cyc.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < a_done_cyc.size()) begin
                checkOutput($sformatf("%s_done_cycle%0d", tag, k), 32'(a_done_cyc[k]), 32'(t0 + 4 * (k + 1)));
                checkOutput($sformatf("%s_word%0d", tag, k), a_done_dat[k], exp_w[k]);
            end
        end
    endtask

    initial begin
        logic [7:0]  pkt[16];
        logic [31:0] pat;
        int          t0;
        int          len;

        pkt = '{8'h1B, 8'h00, 8'h05, 8'h20, 8'h01, 8'h00, 8'h00, 8'h05,
                8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00};

        // Reset held: outputs zero, credit mirrors the FSM credit.
        applyStimulus(0, 0, 8'h00, 0);
        crd = 1'b1;
        #1;
        checkOutput("rst_cfg_crd_hi", 32'(a_cfg_crd), 32'd1);
        crd = 1'b0;
        #1;
        checkOutput("rst_cfg_crd_lo", 32'(a_cfg_crd), 32'd0);
        applyStimulus(1, 1, 8'h5A, 1);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("rst_pl_vld", 32'(a_pl_cfg_vld), 32'd0);
        checkOutput("rst_data", a_received_data, 32'd0);
        i_rst = 1'b1;
        applyStimulus(0, 1, 8'h00, 0);
        applyStimulus(0, 1, 8'h00, 0);

        // Full NC=8 packet.
        clearLogs();
        t0 = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1, pkt[i], 0);
            if (i == 0) t0 = cyc;
        end
        repeat (3) applyStimulus(0, 1, 8'h00, 0);
        checkWords("pkt", t0, 32'h2005001B, 32'h05000001, 32'h12345678, 32'h00000001);
        checkOutput("pkt_pl_vld_cycles", 32'(a_plvld_n), 32'd16);

        // Abort after 6 beats.
        clearLogs();
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 8'(8'h11 * (i + 1)), 0);
        repeat (3) applyStimulus(0, 1, 8'h00, 0);
        checkOutput("abort_done_count", 32'(a_done_cyc.size()), 32'd1);
        checkOutput("abort_ferr_count", 32'(a_ferr_n), CHK ? 32'd1 : 32'd0);
        checkOutput("abort_phase", 32'(a_phase_idx), 32'd0);
        checkOutput("abort_pl_vld", 32'(a_pl_cfg_vld), 32'd0);
        checkOutput("abort_data_held", a_received_data, 32'h44332211);

        // Packet without credit.
        clearLogs();
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 8'(8'hC0 + i), 1);
        repeat (3) applyStimulus(0, 0, 8'h00, 0);
        checkOutput("nocrd_ovf_count", 32'(a_ovf_n), CHK ? 32'd1 : 32'd0);
        checkOutput("nocrd_done_count", 32'(a_done_cyc.size()), CHK ? 32'd0 : 32'd2);
        crd = 1'b1;
        #1;
        checkOutput("nocrd_idle_crd", 32'(a_cfg_crd), 32'd1);

        // NC=1 word of 32 single-bit beats.
        clearLogs();
        pat = 32'hA5A5A5A5;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1, 1, 8'($urandom), pat[i]);
            if (i == 0) t0 = cyc;
        end
        repeat (3) applyStimulus(0, 1, 8'h00, 0);
        checkOutput("nc1_done_count", 32'(b_done_cyc.size()), 32'd1);
        if (b_done_cyc.size() > 0) begin
            checkOutput("nc1_done_cycle", 32'(b_done_cyc[0]), 32'(t0 + 32));
            checkOutput("nc1_word", b_done_dat[0], 32'hA5A5A5A5);
        end

        // Reset during phase 2 beat 2, then a fresh packet.
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, pkt[i], 1);
        vld    = 1'b1;
        beat_a = 8'hEE;
        clearLogs();
        i_rst  = 1'b0;
        #1;
        checkOutput("midrst_pl_vld", 32'(a_pl_cfg_vld), 32'd0);
        checkOutput("midrst_phase", 32'(a_phase_idx), 32'd0);
        checkOutput("midrst_data", a_received_data, 32'd0);
        applyStimulus(0, 1, 8'h00, 0);
        applyStimulus(0, 1, 8'h00, 0);
        i_rst = 1'b1;
        applyStimulus(0, 1, 8'h00, 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1, 8'(i), 0);
            if (i == 0) t0 = cyc;
        end
        repeat (3) applyStimulus(0, 1, 8'h00, 0);
        checkWords("postrst", t0, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
        checkOutput("postrst_ferr_count", 32'(a_ferr_n), 32'd0);

        // Random packets of random length with random credit and gaps.
        for (int p = 0; p < 200; p++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                applyStimulus(1, ($urandom_range(0, 9) != 0), 8'($urandom), 1'($urandom));
            end
            repeat ($urandom_range(1, 3)) applyStimulus(0, 1'($urandom), 8'($urandom), 1'($urandom));
        end
        repeat (3) applyStimulus(0, 1, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
